// File: rtl/rob_trap_seq_if.sv
// -----------------------------------------------------------------------------
// rob_trap_seq_if
//   Signal bundle between the ROB head / branch unit / csr unit / fetch and the
//   retire/trap sequencer (rob_trap_seq).
//   master : the sequencer (drives head_pop, retire report, trap report,
//            flush and fetch redirect)
//   slave  : the surrounding pipeline (drives head entry, branch flush, tvec)
// -----------------------------------------------------------------------------
interface rob_trap_seq_if;
   // ROB head entry
   logic        head_valid;
   logic        head_done;
   logic        head_error;
   logic [4:0]  head_ecause;
   logic [6:0]  head_robid;
   logic [29:0] head_pc;
   logic [31:0] head_tval;
   logic        head_pop;
   // branch unit
   logic        br_flush;
   logic [29:0] br_target;
   // csr unit
   logic [29:0] csr_tvec;
   logic        rob_ret_valid;
   logic [6:0]  rob_csr_head;
   logic        rob_csr_valid;
   logic [29:0] rob_csr_epc;
   logic [4:0]  rob_csr_ecause;
   logic [31:0] rob_csr_tval;
   // pipeline / fetch
   logic        rob_flush;
   logic        fetch_redir;
   logic [29:0] fetch_redir_pc;

   modport master (
      input  head_valid, head_done, head_error, head_ecause, head_robid,
             head_pc, head_tval, br_flush, br_target, csr_tvec,
      output head_pop, rob_ret_valid, rob_csr_head, rob_csr_valid,
             rob_csr_epc, rob_csr_ecause, rob_csr_tval, rob_flush,
             fetch_redir, fetch_redir_pc
   );

   modport slave (
      output head_valid, head_done, head_error, head_ecause, head_robid,
             head_pc, head_tval, br_flush, br_target, csr_tvec,
      input  head_pop, rob_ret_valid, rob_csr_head, rob_csr_valid,
             rob_csr_epc, rob_csr_ecause, rob_csr_tval, rob_flush,
             fetch_redir, fetch_redir_pc
   );
endinterface

// File: rtl/rob_trap_seq.sv
// -----------------------------------------------------------------------------
// rob_trap_seq
//   Retire/trap sequencer at the ROB head.
//   - Retires one completed, non-excepting head entry per cycle (head_pop is
//     combinational, the retire report to csr follows one cycle later).
//   - An excepting head entry is not retired: its pc/cause/tval are reported
//     to csr (REPORT), the pipeline is flushed for FLUSH_HOLD cycles (FLUSH),
//     then fetch is redirected to csr_tvec (REDIR).
//   - A branch-unit flush taken while idle skips REPORT and redirects fetch to
//     the latched branch target. A trap in the same cycle wins.
// Ports
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : rob_trap_seq_if.master (head entry, branch flush, csr, fetch)
// -----------------------------------------------------------------------------
module rob_trap_seq #(
   parameter int unsigned FLUSH_HOLD = 2
) (
   input  logic           clk,
   input  logic           rst,
   rob_trap_seq_if.master bus
);

   localparam int unsigned CW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REPORT,
      S_FLUSH,
      S_REDIR
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_is_trap;
   logic [29:0]   r_br_target;

   logic          r_ret_valid;
   logic [6:0]    r_csr_head;
   logic          r_csr_valid;
   logic [29:0]   r_epc;
   logic [4:0]    r_ecause;
   logic [31:0]   r_tval;
   logic          r_flush;
   logic          r_redir;
   logic [29:0]   r_redir_pc;

   logic          w_idle;
   logic          w_retire;
   logic          w_trap;

   assign w_idle   = (r_state == S_IDLE);
   // rst gates the pop so no entry is dequeued while the sequencer is reset
   assign w_retire = w_idle & ~rst & bus.head_valid & bus.head_done & ~bus.head_error;
   assign w_trap   = w_idle & ~rst & bus.head_valid & bus.head_done &  bus.head_error;

   assign bus.head_pop       = w_retire;
   assign bus.rob_ret_valid  = r_ret_valid;
   assign bus.rob_csr_head   = r_csr_head;
   assign bus.rob_csr_valid  = r_csr_valid;
   assign bus.rob_csr_epc    = r_epc;
   assign bus.rob_csr_ecause = r_ecause;
   assign bus.rob_csr_tval   = r_tval;
   assign bus.rob_flush      = r_flush;
   assign bus.fetch_redir    = r_redir;
   assign bus.fetch_redir_pc = r_redir_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_is_trap   <= 1'b0;
         r_br_target <= '0;
         r_ret_valid <= 1'b0;
         r_csr_head  <= '0;
         r_csr_valid <= 1'b0;
         r_epc       <= '0;
         r_ecause    <= '0;
         r_tval      <= '0;
         r_flush     <= 1'b0;
         r_redir     <= 1'b0;
         r_redir_pc  <= '0;
      end else begin
         r_ret_valid <= w_retire;
         r_csr_valid <= 1'b0;
         r_redir     <= 1'b0;
         if (w_retire) begin
            r_csr_head <= bus.head_robid;
         end

         case (r_state)
            S_IDLE: begin
               if (w_trap) begin
                  // the older trapping instruction flushes any same-cycle branch
                  r_epc       <= bus.head_pc;
                  r_ecause    <= bus.head_ecause;
                  r_tval      <= bus.head_tval;
                  r_is_trap   <= 1'b1;
                  r_csr_valid <= 1'b1;
                  r_state     <= S_REPORT;
               end else if (bus.br_flush) begin
                  r_br_target <= bus.br_target;
                  r_is_trap   <= 1'b0;
                  r_flush     <= 1'b1;
                  r_cnt       <= CW'(FLUSH_HOLD - 1);
                  r_state     <= S_FLUSH;
               end
            end
            S_REPORT: begin
               r_flush <= 1'b1;
               r_cnt   <= CW'(FLUSH_HOLD - 1);
               r_state <= S_FLUSH;
            end
            S_FLUSH: begin
               if (r_cnt == '0) begin
                  // tvec is sampled here, after csr has consumed the report
                  r_flush    <= 1'b0;
                  r_redir    <= 1'b1;
                  r_redir_pc <= r_is_trap ? bus.csr_tvec : r_br_target;
                  r_state    <= S_REDIR;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_REDIR: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rob_trap_seq.sv
module tb_rob_trap_seq;

   localparam int H  = 2;
   localparam int SZ = 320;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   rob_trap_seq_if u_if ();

   rob_trap_seq #(.FLUSH_HOLD(H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // per-cycle stimulus of the current window
   logic        s_rst   [SZ];
   logic        s_valid [SZ];
   logic        s_done  [SZ];
   logic        s_err   [SZ];
   logic [4:0]  s_cause [SZ];
   logic [6:0]  s_robid [SZ];
   logic [29:0] s_pc    [SZ];
   logic [31:0] s_tval  [SZ];
   logic        s_br    [SZ];
   logic [29:0] s_brt   [SZ];
   logic [29:0] s_tvec  [SZ];

   // expected per-cycle outputs
   logic        e_pop   [SZ];
   logic        e_ret   [SZ];
   logic [6:0]  e_head  [SZ];
   logic        e_csr   [SZ];
   logic [29:0] e_epc   [SZ];
   logic [4:0]  e_cause [SZ];
   logic [31:0] e_tval  [SZ];
   logic        e_flush [SZ];
   logic        e_redir [SZ];
   logic [29:0] e_rpc   [SZ];
   logic        sch_v   [SZ];
   logic [29:0] sch_pc  [SZ];

   task automatic clear_stim();
      for (int j = 0; j < SZ; j++) begin
         s_rst[j] = 1'b0; s_valid[j] = 1'b0; s_done[j] = 1'b0; s_err[j] = 1'b0;
         s_cause[j] = '0; s_robid[j] = '0; s_pc[j] = '0; s_tval[j] = '0;
         s_br[j] = 1'b0; s_brt[j] = '0; s_tvec[j] = 30'h100;
      end
      s_rst[0] = 1'b1;
   endtask

   // Reference model: an accepted trap at cycle c schedules a report at c+1,
   // flush over c+2..c+1+H and a redirect at c+2+H to the tvec seen at c+1+H;
   // a branch flush at c schedules flush c+1..c+H and redirect at c+1+H.
   // Nothing new is accepted until the redirect cycle has passed.
   task automatic build_model(input int len);
      int busy_end;
      int r;
      busy_end = -1;
      for (int j = 0; j < SZ; j++) begin
         e_pop[j] = 1'b0; e_ret[j] = 1'b0; e_csr[j] = 1'b0; e_flush[j] = 1'b0;
         e_redir[j] = 1'b0; sch_v[j] = 1'b0; sch_pc[j] = '0;
         e_head[j] = '0; e_epc[j] = '0; e_cause[j] = '0; e_tval[j] = '0; e_rpc[j] = '0;
      end
      for (int i = 0; i < len; i++) begin
         e_head[i+1]  = e_head[i];
         e_epc[i+1]   = e_epc[i];
         e_cause[i+1] = e_cause[i];
         e_tval[i+1]  = e_tval[i];
         e_rpc[i+1]   = sch_v[i+1] ? sch_pc[i+1] : e_rpc[i];
         if (s_rst[i]) begin
            for (int j = i + 1; j < SZ; j++) begin
               e_ret[j] = 1'b0; e_csr[j] = 1'b0; e_flush[j] = 1'b0;
               e_redir[j] = 1'b0; sch_v[j] = 1'b0;
            end
            e_head[i+1] = '0; e_epc[i+1] = '0; e_cause[i+1] = '0;
            e_tval[i+1] = '0; e_rpc[i+1] = '0;
            busy_end = i;
         end else if (i > busy_end) begin
            if (s_valid[i] && s_done[i] && !s_err[i]) begin
               e_pop[i] = 1'b1;
               e_ret[i+1] = 1'b1;
               e_head[i+1] = s_robid[i];
            end
            if (s_valid[i] && s_done[i] && s_err[i]) begin
               e_csr[i+1]   = 1'b1;
               e_epc[i+1]   = s_pc[i];
               e_cause[i+1] = s_cause[i];
               e_tval[i+1]  = s_tval[i];
               for (int k = i + 2; k <= i + 1 + H; k++) e_flush[k] = 1'b1;
               r = i + 2 + H;
               e_redir[r] = 1'b1; sch_v[r] = 1'b1; sch_pc[r] = s_tvec[r-1];
               busy_end = r;
            end else if (s_br[i]) begin
               for (int k = i + 1; k <= i + H; k++) e_flush[k] = 1'b1;
               r = i + 1 + H;
               e_redir[r] = 1'b1; sch_v[r] = 1'b1; sch_pc[r] = s_brt[i];
               busy_end = r;
            end
         end
      end
   endtask

   task automatic drive_cycle(input int i);
      rst               = s_rst[i];
      u_if.head_valid   = s_valid[i];
      u_if.head_done    = s_done[i];
      u_if.head_error   = s_err[i];
      u_if.head_ecause  = s_cause[i];
      u_if.head_robid   = s_robid[i];
      u_if.head_pc      = s_pc[i];
      u_if.head_tval    = s_tval[i];
      u_if.br_flush     = s_br[i];
      u_if.br_target    = s_brt[i];
      u_if.csr_tvec     = s_tvec[i];
   endtask

   task automatic test_reset();
      clear_stim();
      drive_cycle(0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (u_if.head_pop !== 1'b0) begin errors++; $display("FAIL reset pop got %b exp 0", u_if.head_pop); end
      checks++; if (u_if.rob_ret_valid !== 1'b0) begin errors++; $display("FAIL reset ret_valid got %b exp 0", u_if.rob_ret_valid); end
      checks++; if (u_if.rob_csr_head !== 7'd0) begin errors++; $display("FAIL reset csr_head got %h exp 0", u_if.rob_csr_head); end
      checks++; if (u_if.rob_csr_valid !== 1'b0) begin errors++; $display("FAIL reset csr_valid got %b exp 0", u_if.rob_csr_valid); end
      checks++; if (u_if.rob_csr_epc !== 30'd0) begin errors++; $display("FAIL reset epc got %h exp 0", u_if.rob_csr_epc); end
      checks++; if (u_if.rob_csr_ecause !== 5'd0) begin errors++; $display("FAIL reset ecause got %h exp 0", u_if.rob_csr_ecause); end
      checks++; if (u_if.rob_csr_tval !== 32'd0) begin errors++; $display("FAIL reset tval got %h exp 0", u_if.rob_csr_tval); end
      checks++; if (u_if.rob_flush !== 1'b0) begin errors++; $display("FAIL reset flush got %b exp 0", u_if.rob_flush); end
      checks++; if (u_if.fetch_redir !== 1'b0) begin errors++; $display("FAIL reset redir got %b exp 0", u_if.fetch_redir); end
      checks++; if (u_if.fetch_redir_pc !== 30'd0) begin errors++; $display("FAIL reset redir_pc got %h exp 0", u_if.fetch_redir_pc); end
      @(posedge clk); #1;
   endtask

   // T1 back-to-back retire of robids 5,6,7 and T6 stall then single retire
   task automatic test_back_to_back_stall();
      int len;
      len = 16;
      clear_stim();
      for (int j = 1; j <= 3; j++) begin
         s_valid[j] = 1'b1; s_done[j] = 1'b1; s_robid[j] = 7'(4 + j);
      end
      for (int j = 5; j <= 8; j++) begin
         s_valid[j] = 1'b1; s_done[j] = (j == 8); s_robid[j] = 7'd9;
      end
      build_model(len);
      for (int i = 0; i < len; i++) begin
         drive_cycle(i);
         @(negedge clk);
         if (i > 0) begin
            checks++; if (u_if.head_pop !== e_pop[i]) begin errors++; $display("FAIL b2b pop cyc %0d got %b exp %b", i, u_if.head_pop, e_pop[i]); end
            checks++; if (u_if.rob_ret_valid !== e_ret[i]) begin errors++; $display("FAIL b2b ret_valid cyc %0d got %b exp %b", i, u_if.rob_ret_valid, e_ret[i]); end
            checks++; if (u_if.rob_csr_head !== e_head[i]) begin errors++; $display("FAIL b2b csr_head cyc %0d got %h exp %h", i, u_if.rob_csr_head, e_head[i]); end
            checks++; if (u_if.rob_csr_valid !== e_csr[i]) begin errors++; $display("FAIL b2b csr_valid cyc %0d got %b exp %b", i, u_if.rob_csr_valid, e_csr[i]); end
            checks++; if (u_if.rob_flush !== e_flush[i]) begin errors++; $display("FAIL b2b flush cyc %0d got %b exp %b", i, u_if.rob_flush, e_flush[i]); end
            checks++; if (u_if.fetch_redir !== e_redir[i]) begin errors++; $display("FAIL b2b redir cyc %0d got %b exp %b", i, u_if.fetch_redir, e_redir[i]); end
         end
         @(posedge clk); #1;
      end
   endtask

   // T2 trap, T3 trap+branch in the same cycle, T4 branch flush with a
   // second br_flush during FLUSH, plus retire coinciding with br_flush
   task automatic test_trap_branch();
      int len;
      len = 44;
      clear_stim();
      s_valid[2] = 1'b1; s_done[2] = 1'b1; s_err[2] = 1'b1;
      s_pc[2] = 30'h400; s_cause[2] = 5'd2; s_tval[2] = 32'hDEAD; s_robid[2] = 7'd11;
      s_valid[10] = 1'b1; s_done[10] = 1'b1; s_err[10] = 1'b1;
      s_pc[10] = 30'h123; s_cause[10] = 5'd7; s_tval[10] = 32'h5555_AAAA;
      s_br[10] = 1'b1; s_brt[10] = 30'h80;
      for (int j = 11; j < SZ; j++) s_tvec[j] = 30'h100 + 30'(j);
      s_br[20] = 1'b1; s_brt[20] = 30'h80;
      s_br[22] = 1'b1; s_brt[22] = 30'h3C;
      s_br[30] = 1'b1; s_brt[30] = 30'h2A0;
      s_valid[30] = 1'b1; s_done[30] = 1'b1; s_robid[30] = 7'h41;
      build_model(len);
      for (int i = 0; i < len; i++) begin
         drive_cycle(i);
         @(negedge clk);
         if (i > 0) begin
            checks++; if (u_if.head_pop !== e_pop[i]) begin errors++; $display("FAIL trap pop cyc %0d got %b exp %b", i, u_if.head_pop, e_pop[i]); end
            checks++; if (u_if.rob_ret_valid !== e_ret[i]) begin errors++; $display("FAIL trap ret_valid cyc %0d got %b exp %b", i, u_if.rob_ret_valid, e_ret[i]); end
            checks++; if (u_if.rob_csr_head !== e_head[i]) begin errors++; $display("FAIL trap csr_head cyc %0d got %h exp %h", i, u_if.rob_csr_head, e_head[i]); end
            checks++; if (u_if.rob_csr_valid !== e_csr[i]) begin errors++; $display("FAIL trap csr_valid cyc %0d got %b exp %b", i, u_if.rob_csr_valid, e_csr[i]); end
            checks++; if (u_if.rob_csr_epc !== e_epc[i]) begin errors++; $display("FAIL trap epc cyc %0d got %h exp %h", i, u_if.rob_csr_epc, e_epc[i]); end
            checks++; if (u_if.rob_csr_ecause !== e_cause[i]) begin errors++; $display("FAIL trap ecause cyc %0d got %h exp %h", i, u_if.rob_csr_ecause, e_cause[i]); end
            checks++; if (u_if.rob_csr_tval !== e_tval[i]) begin errors++; $display("FAIL trap tval cyc %0d got %h exp %h", i, u_if.rob_csr_tval, e_tval[i]); end
            checks++; if (u_if.rob_flush !== e_flush[i]) begin errors++; $display("FAIL trap flush cyc %0d got %b exp %b", i, u_if.rob_flush, e_flush[i]); end
            checks++; if (u_if.fetch_redir !== e_redir[i]) begin errors++; $display("FAIL trap redir cyc %0d got %b exp %b", i, u_if.fetch_redir, e_redir[i]); end
            checks++; if (u_if.fetch_redir_pc !== e_rpc[i]) begin errors++; $display("FAIL trap redir_pc cyc %0d got %h exp %h", i, u_if.fetch_redir_pc, e_rpc[i]); end
         end
         @(posedge clk); #1;
      end
   endtask

   // T5 reset asserted in the first FLUSH cycle, then normal retire resumes
   task automatic test_reset_mid();
      int len;
      len = 16;
      clear_stim();
      s_valid[2] = 1'b1; s_done[2] = 1'b1; s_err[2] = 1'b1;
      s_pc[2] = 30'h777; s_cause[2] = 5'd13; s_tval[2] = 32'hCAFE_F00D;
      s_rst[4] = 1'b1;
      for (int j = 6; j <= 8; j++) begin
         s_valid[j] = 1'b1; s_done[j] = 1'b1; s_robid[j] = 7'(14 + j);
      end
      build_model(len);
      for (int i = 0; i < len; i++) begin
         drive_cycle(i);
         @(negedge clk);
         if (i > 0) begin
            checks++; if (u_if.head_pop !== e_pop[i]) begin errors++; $display("FAIL rstmid pop cyc %0d got %b exp %b", i, u_if.head_pop, e_pop[i]); end
            checks++; if (u_if.rob_ret_valid !== e_ret[i]) begin errors++; $display("FAIL rstmid ret_valid cyc %0d got %b exp %b", i, u_if.rob_ret_valid, e_ret[i]); end
            checks++; if (u_if.rob_csr_head !== e_head[i]) begin errors++; $display("FAIL rstmid csr_head cyc %0d got %h exp %h", i, u_if.rob_csr_head, e_head[i]); end
            checks++; if (u_if.rob_csr_valid !== e_csr[i]) begin errors++; $display("FAIL rstmid csr_valid cyc %0d got %b exp %b", i, u_if.rob_csr_valid, e_csr[i]); end
            checks++; if (u_if.rob_csr_epc !== e_epc[i]) begin errors++; $display("FAIL rstmid epc cyc %0d got %h exp %h", i, u_if.rob_csr_epc, e_epc[i]); end
            checks++; if (u_if.rob_csr_tval !== e_tval[i]) begin errors++; $display("FAIL rstmid tval cyc %0d got %h exp %h", i, u_if.rob_csr_tval, e_tval[i]); end
            checks++; if (u_if.rob_flush !== e_flush[i]) begin errors++; $display("FAIL rstmid flush cyc %0d got %b exp %b", i, u_if.rob_flush, e_flush[i]); end
            checks++; if (u_if.fetch_redir !== e_redir[i]) begin errors++; $display("FAIL rstmid redir cyc %0d got %b exp %b", i, u_if.fetch_redir, e_redir[i]); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      int len;
      len = 280;
      clear_stim();
      for (int j = 1; j < len - 10; j++) begin
         s_rst[j]   = ($urandom_range(99, 0) < 2);
         s_valid[j] = ($urandom_range(99, 0) < 85);
         s_done[j]  = ($urandom_range(99, 0) < 75);
         s_err[j]   = ($urandom_range(99, 0) < 15);
         s_cause[j] = 5'($urandom);
         s_robid[j] = 7'($urandom);
         s_pc[j]    = 30'($urandom);
         s_tval[j]  = $urandom;
         s_br[j]    = ($urandom_range(99, 0) < 8);
         s_brt[j]   = 30'($urandom);
         s_tvec[j]  = 30'($urandom);
      end
      build_model(len);
      for (int i = 0; i < len; i++) begin
         drive_cycle(i);
         @(negedge clk);
         if (i > 0) begin
            checks++; if (u_if.head_pop !== e_pop[i]) begin errors++; $display("FAIL rand pop cyc %0d got %b exp %b", i, u_if.head_pop, e_pop[i]); end
            checks++; if (u_if.rob_ret_valid !== e_ret[i]) begin errors++; $display("FAIL rand ret_valid cyc %0d got %b exp %b", i, u_if.rob_ret_valid, e_ret[i]); end
            checks++; if (u_if.rob_csr_head !== e_head[i]) begin errors++; $display("FAIL rand csr_head cyc %0d got %h exp %h", i, u_if.rob_csr_head, e_head[i]); end
            checks++; if (u_if.rob_csr_valid !== e_csr[i]) begin errors++; $display("FAIL rand csr_valid cyc %0d got %b exp %b", i, u_if.rob_csr_valid, e_csr[i]); end
            checks++; if (u_if.rob_csr_epc !== e_epc[i]) begin errors++; $display("FAIL rand epc cyc %0d got %h exp %h", i, u_if.rob_csr_epc, e_epc[i]); end
            checks++; if (u_if.rob_csr_ecause !== e_cause[i]) begin errors++; $display("FAIL rand ecause cyc %0d got %h exp %h", i, u_if.rob_csr_ecause, e_cause[i]); end
            checks++; if (u_if.rob_csr_tval !== e_tval[i]) begin errors++; $display("FAIL rand tval cyc %0d got %h exp %h", i, u_if.rob_csr_tval, e_tval[i]); end
            checks++; if (u_if.rob_flush !== e_flush[i]) begin errors++; $display("FAIL rand flush cyc %0d got %b exp %b", i, u_if.rob_flush, e_flush[i]); end
            checks++; if (u_if.fetch_redir !== e_redir[i]) begin errors++; $display("FAIL rand redir cyc %0d got %b exp %b", i, u_if.fetch_redir, e_redir[i]); end
            checks++; if (u_if.fetch_redir_pc !== e_rpc[i]) begin errors++; $display("FAIL rand redir_pc cyc %0d got %h exp %h", i, u_if.fetch_redir_pc, e_rpc[i]); end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_back_to_back_stall();
      test_trap_branch();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
